// File: rtl/alu_issue.sv
// alu_issue: single-issue front end for the arithmetic ALU.
// Accepts one RV32I OP / OP-IMM instruction at a time, reads operands from an
// internal 32x32 register file, presents them to the ALU for one cycle, then
// waits (bounded by TIMEOUT) for the ALU result and writes it back to rd.
//
// Handshake: instr is taken on a rising edge where instr_valid && instr_ready;
// instr_ready is high only in IDLE. The four ALU qualifiers are high for exactly
// the single ISSUE cycle. result is taken only on a WAIT-state edge where
// result_valid is high; result_valid in any other state is ignored.
module alu_issue #(
    parameter int TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [31:0] lhs,
    output logic        lhs_valid,
    output logic [31:0] rhs,
    output logic        rhs_valid,
    output logic [2:0]  operation,
    output logic        operation_valid,
    output logic [6:0]  metadata,
    output logic        metadata_valid,
    input  logic [31:0] result,
    input  logic        result_valid,
    output logic        retired,
    output logic        error,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] F7_ZERO    = 7'h00;
    localparam logic [6:0] F7_ALT     = 7'h20;

    localparam int          CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [31:0]   regs [32];
    logic [4:0]    rd_q;
    logic [CW-1:0] wait_cnt;

    // Instruction fields
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic        is_op;
    logic        is_op_imm;
    logic        is_shift;
    logic        legal;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] rhs_nxt;
    logic [6:0]  meta_nxt;

    // FSM strobes
    logic accept;
    logic illegal;
    logic writeback;
    logic timeout;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    // Decode, legality check and operand selection for the word on instr
    always_comb begin
        is_op     = (opcode == OPC_OP);
        is_op_imm = (opcode == OPC_OP_IMM);
        is_shift  = (funct3 == 3'd1) || (funct3 == 3'd5);
        legal     = 1'b0;
        if (is_op) begin
            legal = (funct7 == F7_ZERO) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
        end else if (is_op_imm) begin
            if (funct3 == 3'd1)
                legal = (funct7 == F7_ZERO);
            else if (funct3 == 3'd5)
                legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
            else
                legal = 1'b1;
        end

        rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
        rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

        // The ALU shifts by the whole rhs, so shift amounts are cut to 5 bits here
        if (is_op)
            rhs_nxt = is_shift ? {27'd0, rs2_val[4:0]} : rs2_val;
        else
            rhs_nxt = is_shift ? {27'd0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]};

        // For non-shift OP-IMM the funct7 bits are immediate, not an ALU modifier
        meta_nxt = (is_op || is_shift) ? funct7 : F7_ZERO;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic and per-cycle strobes
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        illegal   = 1'b0;
        writeback = 1'b0;
        timeout   = 1'b0;
        case (state)
            S_IDLE: begin
                if (instr_valid) begin
                    if (legal) begin
                        accept    = 1'b1;
                        state_nxt = S_ISSUE;
                    end else begin
                        illegal = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (result_valid) begin
                    writeback = 1'b1;
                    state_nxt = S_IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign instr_ready     = (state == S_IDLE);
    assign lhs_valid       = (state == S_ISSUE);
    assign rhs_valid       = (state == S_ISSUE);
    assign operation_valid = (state == S_ISSUE);
    assign metadata_valid  = (state == S_ISSUE);

    // Operand latches, WAIT cycle counter and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            lhs       <= '0;
            rhs       <= '0;
            operation <= '0;
            metadata  <= '0;
            rd_q      <= '0;
            wait_cnt  <= '0;
            retired   <= 1'b0;
            error     <= 1'b0;
        end else begin
            retired <= writeback;
            error   <= illegal | timeout;
            if (accept) begin
                lhs       <= rs1_val;
                rhs       <= rhs_nxt;
                operation <= funct3;
                metadata  <= meta_nxt;
                rd_q      <= rd;
            end
            if (state == S_WAIT)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
        end
    end

    // Register file; x0 is never written so it stays zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (writeback && (rd_q != 5'd0)) begin
            regs[rd_q] <= result;
        end
    end

    assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue: directed vector table, timeout and reset corner
// sequences, and random instructions checked against an ISA-level model.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] lhs;
    logic        lhs_valid;
    logic [31:0] rhs;
    logic        rhs_valid;
    logic [2:0]  operation;
    logic        operation_valid;
    logic [6:0]  metadata;
    logic        metadata_valid;
    logic [31:0] result;
    logic        result_valid;
    logic        retired;
    logic        error;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int total = 0;
    int bad   = 0;

    // Architectural register model
    logic [31:0] mregs [32];

    // Values seen on the ALU ports by the most recent do_instr
    logic [31:0] cap_lhs, cap_rhs;
    logic [2:0]  cap_op;
    logic [6:0]  cap_meta;
    logic        cap_err;

    typedef struct packed {
        logic [31:0] ins;
        logic        legal;
        logic [31:0] e_lhs;
        logic [31:0] e_rhs;
        logic [2:0]  e_op;
        logic [6:0]  e_meta;
        logic [4:0]  reg_a;
        logic [31:0] reg_v;
    } vec_t;

    vec_t tbl [9];

    alu_issue #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .lhs(lhs), .lhs_valid(lhs_valid),
        .rhs(rhs), .rhs_valid(rhs_valid), .operation(operation),
        .operation_valid(operation_valid), .metadata(metadata),
        .metadata_valid(metadata_valid), .result(result),
        .result_valid(result_valid), .retired(retired), .error(error),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_model;
        for (int i = 0; i < 32; i++) mregs[i] = '0;
    endtask

    // Which encodings the block must accept
    function automatic logic model_legal(input logic [31:0] ins);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        if (ins[6:0] == 7'h33) return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        if (ins[6:0] == 7'h13) begin
            if (f3 == 3'd1) return f7 == 7'h00;
            if (f3 == 3'd5) return (f7 == 7'h00) || (f7 == 7'h20);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // RV32I meaning of an instruction on architectural values
    function automatic logic [31:0] isa_exec(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b_reg);
        logic        is_op;
        logic [31:0] b;
        logic [4:0]  sh;
        is_op = (ins[6:0] == 7'h33);
        b  = is_op ? b_reg : {{20{ins[31]}}, ins[31:20]};
        sh = b[4:0];
        case (ins[14:12])
            3'd0: return (is_op && ins[30]) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return ins[30] ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // Behaviour of the downstream ALU: shifts use the full rhs value
    function automatic logic [31:0] alu_model(input logic [31:0] l, input logic [31:0] r,
                                              input logic [2:0] op, input logic [6:0] meta);
        case (op)
            3'd0: return (meta == 7'h20) ? l - r : l + r;
            3'd1: return l << r;
            3'd2: return ($signed(l) < $signed(r)) ? 32'd1 : 32'd0;
            3'd3: return (l < r) ? 32'd1 : 32'd0;
            3'd4: return l ^ r;
            3'd5: return (meta == 7'h20) ? 32'($signed(l) >>> r) : l >> r;
            3'd6: return l | r;
            default: return l & r;
        endcase
    endfunction

    // Driver: present one instruction and play the ALU.
    // resp=0 withholds the result; dly = extra WAIT cycles before result_valid;
    // spur drives a bogus result_valid during the ISSUE cycle.
    task automatic do_instr(input logic [31:0] ins, input logic resp,
                            input int unsigned dly, input logic spur);
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        legal, is_op, shift;
        logic [31:0] e_rhs, e_res, alu_res, old_rd;
        logic [6:0]  e_meta;
        rd    = ins[11:7];
        f3    = ins[14:12];
        rs1   = ins[19:15];
        rs2   = ins[24:20];
        f7    = ins[31:25];
        is_op = (ins[6:0] == 7'h33);
        shift = (f3 == 3'd1) || (f3 == 3'd5);
        legal = model_legal(ins);
        if (is_op) e_rhs = shift ? {27'd0, mregs[rs2][4:0]} : mregs[rs2];
        else       e_rhs = shift ? {27'd0, ins[24:20]} : {{20{ins[31]}}, ins[31:20]};
        e_meta = (is_op || shift) ? f7 : 7'h00;

        chk("idle_ready", instr_ready, 1);
        instr = ins;
        instr_valid = 1'b1;
        tick;
        instr_valid = 1'b0;
        instr = $urandom;
        cap_err = error;

        if (!legal) begin
            chk("ill_error", error, 1);
            chk("ill_valids", {lhs_valid, rhs_valid, operation_valid, metadata_valid}, 0);
            chk("ill_ready", instr_ready, 1);
            tick;
            chk("ill_error_drop", error, 0);
            chk("ill_ready2", instr_ready, 1);
            return;
        end

        chk("issue_valids", {lhs_valid, rhs_valid, operation_valid, metadata_valid}, 4'hf);
        chk("issue_lhs", lhs, mregs[rs1]);
        chk("issue_rhs", rhs, e_rhs);
        chk("issue_op", operation, f3);
        chk("issue_meta", metadata, e_meta);
        chk("issue_status", {instr_ready, retired, error}, 0);
        cap_lhs  = lhs;
        cap_rhs  = rhs;
        cap_op   = operation;
        cap_meta = metadata;
        alu_res  = alu_model(lhs, rhs, operation, metadata);
        result       = spur ? $urandom : alu_res;
        result_valid = spur;
        tick;
        result_valid = 1'b0;
        result       = alu_res;
        chk("wait_valids", {lhs_valid, rhs_valid, operation_valid, metadata_valid}, 0);
        old_rd = mregs[rd];

        if (!resp) begin
            repeat (3) begin
                tick;
                chk("tmo_early", {error, instr_ready, retired}, 0);
            end
            tick;
            chk("tmo_error", error, 1);
            chk("tmo_ready", instr_ready, 1);
            chk("tmo_retired", retired, 0);
            dbg_addr = rd;
            #1;
            chk("tmo_nowrite", dbg_data, old_rd);
            return;
        end

        for (int k = 0; k < int'(dly); k++) begin
            tick;
            chk("wait_hold", {retired, error, instr_ready}, 0);
        end
        result_valid = 1'b1;
        tick;
        result_valid = 1'b0;
        chk("wb_retired", retired, 1);
        chk("wb_ready", instr_ready, 1);
        chk("wb_error", error, 0);
        e_res = isa_exec(ins, mregs[rs1], mregs[rs2]);
        if (rd != 5'd0) mregs[rd] = e_res;
        dbg_addr = rd;
        #1;
        chk("wb_dbg", dbg_data, mregs[rd]);
    endtask

    initial begin
        logic [31:0] ins;
        logic [6:0]  opc, f7;

        rst = 1'b1;
        instr = '0;
        instr_valid = 1'b0;
        result = '0;
        result_valid = 1'b0;
        dbg_addr = '0;
        clear_model();

        // Reset state
        repeat (2) tick;
        chk("rst_ready", instr_ready, 1);
        chk("rst_valids", {lhs_valid, rhs_valid, operation_valid, metadata_valid}, 0);
        chk("rst_pulses", {retired, error}, 0);
        chk("rst_lhs", lhs, 0);
        chk("rst_rhs", rhs, 0);
        chk("rst_opmeta", {operation, metadata}, 0);
        dbg_addr = 5'd1;
        #1;
        chk("rst_x1", dbg_data, 0);
        rst = 1'b0;
        tick;

        // Spurious result in IDLE
        result = 32'hdead_beef;
        result_valid = 1'b1;
        tick;
        result_valid = 1'b0;
        chk("spur_idle_retired", retired, 0);
        chk("spur_idle_ready", instr_ready, 1);
        dbg_addr = 5'd1;
        #1;
        chk("spur_idle_x1", dbg_data, 0);

        // Directed vectors
        tbl[0] = '{32'h00500093, 1'b1, 32'h0,        32'h5,        3'd0, 7'h00, 5'd1, 32'h5};
        tbl[1] = '{32'hfff00113, 1'b1, 32'h0,        32'hffffffff, 3'd0, 7'h00, 5'd2, 32'hffffffff};
        tbl[2] = '{32'h402081b3, 1'b1, 32'h5,        32'hffffffff, 3'd0, 7'h20, 5'd3, 32'h6};
        tbl[3] = '{32'h40415213, 1'b1, 32'hffffffff, 32'h4,        3'd5, 7'h20, 5'd4, 32'hffffffff};
        tbl[4] = '{32'h02100313, 1'b1, 32'h0,        32'h21,       3'd0, 7'h00, 5'd6, 32'h21};
        tbl[5] = '{32'h006092b3, 1'b1, 32'h5,        32'h1,        3'd1, 7'h00, 5'd5, 32'ha};
        tbl[6] = '{32'h022081b3, 1'b0, 32'h0,        32'h0,        3'd0, 7'h00, 5'd3, 32'h6};
        tbl[7] = '{32'h00700013, 1'b1, 32'h0,        32'h7,        3'd0, 7'h00, 5'd0, 32'h0};
        tbl[8] = '{32'h00000003, 1'b0, 32'h0,        32'h0,        3'd0, 7'h00, 5'd1, 32'h5};
        for (int i = 0; i < 9; i++) begin
            do_instr(tbl[i].ins, 1'b1, 0, 1'b0);
            chk("tbl_err", cap_err, !tbl[i].legal);
            if (tbl[i].legal) begin
                chk("tbl_lhs", cap_lhs, tbl[i].e_lhs);
                chk("tbl_rhs", cap_rhs, tbl[i].e_rhs);
                chk("tbl_opmeta", {cap_op, cap_meta}, {tbl[i].e_op, tbl[i].e_meta});
            end
            dbg_addr = tbl[i].reg_a;
            #1;
            chk("tbl_reg", dbg_data, tbl[i].reg_v);
        end

        // Timeout: ADDI x7,x0,9 with no ALU response
        do_instr(32'h00900393, 1'b0, 0, 1'b0);
        dbg_addr = 5'd7;
        #1;
        chk("tmo_x7", dbg_data, 0);
        tick;
        chk("tmo_error_drop", error, 0);

        // Random instructions
        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: opc = 7'h33;
                5, 6, 7, 8:    opc = 7'h13;
                default:       opc = 7'($urandom_range(0, 127));
            endcase
            case ($urandom_range(0, 3))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                2:       f7 = 7'h01;
                default: f7 = 7'($urandom_range(0, 127));
            endcase
            ins = {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), opc};
            do_instr(ins, ($urandom_range(0, 11) != 0), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)));
        end

        // Reset during WAIT: ADDI x8,x0,3 then reset, then a late result
        instr = 32'h00300413;
        instr_valid = 1'b1;
        tick;
        instr_valid = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        clear_model();
        chk("rstw_pulses", {retired, error}, 0);
        chk("rstw_ready", instr_ready, 1);
        result = 32'h3;
        result_valid = 1'b1;
        tick;
        result_valid = 1'b0;
        chk("rstw_late_retired", {retired, error}, 0);
        chk("rstw_late_ready", instr_ready, 1);
        dbg_addr = 5'd8;
        #1;
        chk("rstw_x8", dbg_data, 0);
        dbg_addr = 5'd1;
        #1;
        chk("rstw_x1", dbg_data, 0);
        do_instr(32'h00500093, 1'b1, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
